// File: rtl/skin_patch_bbox.sv
// skin_patch_bbox
// Scans a snapshot of the GRID_W x GRID_H skin patch map one cell per clock
// and reports the bounding box, skin cell count and found flag once per frame.
// Optional build macro SKIN_ISOLATE_FILTER_EN: a skin cell is counted only if
// a horizontal neighbour in the same row is also skin (row edges are non-skin).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for iStart; outputs hold the previous frame result
// SCAN  | one shadow-map cell evaluated per clock, raster order
// DONE  | results registered to the outputs, oValid pulses next cycle

module skin_patch_bbox #(
    parameter int GRID_W    = 40,
    parameter int GRID_H    = 30,
    parameter int MIN_COUNT = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  iStart,
    input  logic [GRID_W*GRID_H-1:0]              iSkinFrame,
    output logic                                  oBusy,
    output logic                                  oValid,
    output logic                                  oFound,
    output logic [$clog2(GRID_W)-1:0]             oMinX,
    output logic [$clog2(GRID_W)-1:0]             oMaxX,
    output logic [$clog2(GRID_H)-1:0]             oMinY,
    output logic [$clog2(GRID_H)-1:0]             oMaxY,
    output logic [$clog2(GRID_W*GRID_H+1)-1:0]    oCount
);

    localparam int N  = GRID_W * GRID_H;
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int CW = $clog2(N + 1);
    localparam int IW = $clog2(N);

    localparam logic [XW-1:0] X_LAST   = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(GRID_H - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [CW-1:0] MIN_CNT  = CW'(MIN_COUNT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q,  state_d;
    logic [N-1:0]    shadow_q, shadow_d;
    logic [XW-1:0]   x_q,      x_d;
    logic [YW-1:0]   y_q,      y_d;
    logic [IW-1:0]   idx_q,    idx_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic [XW-1:0]   min_x_q,  min_x_d;
    logic [XW-1:0]   max_x_q,  max_x_d;
    logic [YW-1:0]   min_y_q,  min_y_d;
    logic [YW-1:0]   max_y_q,  max_y_d;

    logic            busy_q,   busy_d;
    logic            valid_q,  valid_d;
    logic            found_q,  found_d;
    logic [XW-1:0]   o_min_x_q, o_min_x_d;
    logic [XW-1:0]   o_max_x_q, o_max_x_d;
    logic [YW-1:0]   o_min_y_q, o_min_y_d;
    logic [YW-1:0]   o_max_y_q, o_max_y_d;
    logic [CW-1:0]   o_count_q, o_count_d;

    logic            cell_hit;

`ifdef SKIN_ISOLATE_FILTER_EN
    logic [IW-1:0]   idx_m1;
    logic [IW-1:0]   idx_p1;
    logic            left_skin;
    logic            right_skin;

    // Decide whether the current cell counts: skin with a skin horizontal neighbour
    always_comb begin
        idx_m1     = (idx_q == '0)       ? idx_q : idx_q - 1'b1;
        idx_p1     = (idx_q == IDX_LAST) ? idx_q : idx_q + 1'b1;
        left_skin  = (x_q != '0)     && shadow_q[idx_m1];
        right_skin = (x_q != X_LAST) && shadow_q[idx_p1];
        cell_hit   = shadow_q[idx_q] && (left_skin || right_skin);
    end
`else
    // Decide whether the current cell counts: any skin cell
    always_comb begin
        cell_hit = shadow_q[idx_q];
    end
`endif

    // Next-state and next-output computation for the scan controller
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        x_d       = x_q;
        y_d       = y_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        min_x_d   = min_x_q;
        max_x_d   = max_x_q;
        min_y_d   = min_y_q;
        max_y_d   = max_y_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        found_d   = found_q;
        o_min_x_d = o_min_x_q;
        o_max_x_d = o_max_x_q;
        o_min_y_d = o_min_y_q;
        o_max_y_d = o_max_y_q;
        o_count_d = o_count_q;

        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    shadow_d = iSkinFrame;
                    x_d      = '0;
                    y_d      = '0;
                    idx_d    = '0;
                    cnt_d    = '0;
                    min_x_d  = X_LAST;
                    max_x_d  = '0;
                    min_y_d  = Y_LAST;
                    max_y_d  = '0;
                    busy_d   = 1'b1;
                    state_d  = S_SCAN;
                end
            end

            S_SCAN: begin
                if (cell_hit) begin
                    cnt_d = cnt_q + 1'b1;
                    if (x_q < min_x_q) min_x_d = x_q;
                    if (x_q > max_x_q) max_x_d = x_q;
                    if (y_q < min_y_q) min_y_d = y_q;
                    if (y_q > max_y_q) max_y_d = y_q;
                end
                if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                valid_d   = 1'b1;
                found_d   = (cnt_q >= MIN_CNT);
                o_count_d = cnt_q;
                // An empty frame reports a zero box rather than the inverted init values
                if (cnt_q == '0) begin
                    o_min_x_d = '0;
                    o_max_x_d = '0;
                    o_min_y_d = '0;
                    o_max_y_d = '0;
                end else begin
                    o_min_x_d = min_x_q;
                    o_max_x_d = max_x_q;
                    o_min_y_d = min_y_q;
                    o_max_y_d = max_y_q;
                end
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, scan working registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shadow_q  <= '0;
            x_q       <= '0;
            y_q       <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            min_x_q   <= '0;
            max_x_q   <= '0;
            min_y_q   <= '0;
            max_y_q   <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            found_q   <= 1'b0;
            o_min_x_q <= '0;
            o_max_x_q <= '0;
            o_min_y_q <= '0;
            o_max_y_q <= '0;
            o_count_q <= '0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            x_q       <= x_d;
            y_q       <= y_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            min_x_q   <= min_x_d;
            max_x_q   <= max_x_d;
            min_y_q   <= min_y_d;
            max_y_q   <= max_y_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            found_q   <= found_d;
            o_min_x_q <= o_min_x_d;
            o_max_x_q <= o_max_x_d;
            o_min_y_q <= o_min_y_d;
            o_max_y_q <= o_max_y_d;
            o_count_q <= o_count_d;
        end
    end

    assign oBusy  = busy_q;
    assign oValid = valid_q;
    assign oFound = found_q;
    assign oMinX  = o_min_x_q;
    assign oMaxX  = o_max_x_q;
    assign oMinY  = o_min_y_q;
    assign oMaxY  = o_max_y_q;
    assign oCount = o_count_q;

endmodule

// File: tb/tb_skin_patch_bbox.sv
// Directed bench for skin_patch_bbox: default instance plus a MIN_COUNT=4 instance.
module tb_skin_patch_bbox;

    localparam int N = 1200;

`ifdef SKIN_ISOLATE_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          iStart;
    logic [N-1:0]  iSkinFrame;

    logic          oBusy, oValid, oFound;
    logic [5:0]    oMinX, oMaxX;
    logic [4:0]    oMinY, oMaxY;
    logic [10:0]   oCount;

    logic          b4_busy, b4_valid, b4_found;
    logic [5:0]    b4_min_x, b4_max_x;
    logic [4:0]    b4_min_y, b4_max_y;
    logic [10:0]   b4_count;

    int total = 0;
    int bad   = 0;

    skin_patch_bbox dut (
        .clk(clk), .rst(rst), .iStart(iStart), .iSkinFrame(iSkinFrame),
        .oBusy(oBusy), .oValid(oValid), .oFound(oFound),
        .oMinX(oMinX), .oMaxX(oMaxX), .oMinY(oMinY), .oMaxY(oMaxY),
        .oCount(oCount)
    );

    skin_patch_bbox #(.MIN_COUNT(4)) dut4 (
        .clk(clk), .rst(rst), .iStart(iStart), .iSkinFrame(iSkinFrame),
        .oBusy(b4_busy), .oValid(b4_valid), .oFound(b4_found),
        .oMinX(b4_min_x), .oMaxX(b4_max_x), .oMinY(b4_min_y), .oMaxY(b4_max_y),
        .oCount(b4_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input int cnt, input int found,
                                input int mnx, input int mxx, input int mny, input int mxy);
        check({tag, ".count"}, 32'(oCount), cnt);
        check({tag, ".found"}, 32'(oFound), found);
        check({tag, ".minx"},  32'(oMinX),  mnx);
        check({tag, ".maxx"},  32'(oMaxX),  mxx);
        check({tag, ".miny"},  32'(oMinY),  mny);
        check({tag, ".maxy"},  32'(oMaxY),  mxy);
    endtask

    // Pulse iStart with the given map, then watch up to max_cyc clocks.
    // clr_at/re_at/rst_at are clock indices after the iStart edge (-1 = unused).
    task automatic run_frame(input logic [N-1:0] map, input int clr_at, input int re_at,
                             input int rst_at, input int max_cyc,
                             output int lat, output int busy_n);
        iSkinFrame = map;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        lat = -1;
        busy_n = oBusy ? 1 : 0;
        for (int k = 1; k <= max_cyc && lat < 0; k++) begin
            tick();
            if (k == clr_at) iSkinFrame = '0;
            if (k == re_at) iStart = 1'b1;
            else if (k == re_at + 1) iStart = 1'b0;
            if (k == rst_at) rst = 1'b1;
            else if (k == rst_at + 1) rst = 1'b0;
            if (oBusy) busy_n++;
            if (oValid) lat = k;
        end
        iStart = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] map;
        int lat;
        int busy_n;

        rst = 1'b1;
        iStart = 1'b0;
        iSkinFrame = '0;
        repeat (3) tick();
        check("rst.busy",  32'(oBusy),  0);
        check("rst.valid", 32'(oValid), 0);
        check_result("rst", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        // all-zero map: latency, busy duration, empty-frame result
        map = '0;
        run_frame(map, -1, -1, -1, 1400, lat, busy_n);
        check("zero.latency", lat, 1201);
        check("zero.busy_cycles", busy_n, 1200);
        check("zero.busy_in_valid", 32'(oBusy), 0);
        check_result("zero", 0, 0, 0, 0, 0, 0);
        tick();
        check("zero.valid_one_cycle", 32'(oValid), 0);
        check("zero.hold_count", 32'(oCount), 0);

        // single cell at (5,3)
        map = '0;
        map[125] = 1'b1;
        run_frame(map, -1, -1, -1, 1400, lat, busy_n);
        check("single.latency", lat, 1201);
        if (FILT) check_result("single", 0, 0, 0, 0, 0, 0);
        else      check_result("single", 1, 1, 5, 5, 3, 3);

        // all-ones map, started back-to-back in the IDLE cycle after DONE
        map = '1;
        run_frame(map, -1, -1, -1, 1400, lat, busy_n);
        check("ones.latency", lat, 1201);
        check_result("ones", 1200, 1, 0, 39, 0, 29);

        // rectangle x 10..14, y 20..22; input cleared and iStart retriggered mid-scan
        map = '0;
        for (int y = 20; y <= 22; y++)
            for (int x = 10; x <= 14; x++)
                map[y*40 + x] = 1'b1;
        run_frame(map, 5, 600, -1, 1400, lat, busy_n);
        check("rect.latency", lat, 1201);
        check_result("rect", 15, 1, 10, 14, 20, 22);
        check("rect.b4_found", 32'(b4_found), 1);
        repeat (5) tick();
        check("rect.no_second_valid", 32'(oValid), 0);
        check("rect.idle_busy", 32'(oBusy), 0);
        check("rect.hold_count", 32'(oCount), 15);

        // reset at scan cycle 700: abort, no oValid, outputs cleared
        map = '1;
        run_frame(map, -1, -1, 700, 1400, lat, busy_n);
        check("abort.no_valid", lat, -1);
        check("abort.busy", 32'(oBusy), 0);
        check_result("abort", 0, 0, 0, 0, 0, 0);

        // recovery frame: three isolated cells, also checks MIN_COUNT=4 instance
        map = '0;
        map[42]   = 1'b1;   // (2,1)
        map[420]  = 1'b1;   // (20,10)
        map[1035] = 1'b1;   // (35,25)
        run_frame(map, -1, -1, -1, 1400, lat, busy_n);
        check("iso.latency", lat, 1201);
        if (FILT) begin
            check_result("iso", 0, 0, 0, 0, 0, 0);
            check("iso.b4_count", 32'(b4_count), 0);
            check("iso.b4_found", 32'(b4_found), 0);
            check("iso.b4_minx",  32'(b4_min_x), 0);
        end else begin
            check_result("iso", 3, 1, 2, 35, 1, 25);
            check("iso.b4_count", 32'(b4_count), 3);
            check("iso.b4_found", 32'(b4_found), 0);
            check("iso.b4_minx",  32'(b4_min_x), 2);
            check("iso.b4_maxx",  32'(b4_max_x), 35);
            check("iso.b4_miny",  32'(b4_min_y), 1);
            check("iso.b4_maxy",  32'(b4_max_y), 25);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
